// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Launch FSM encoding, byte width and controller modes.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    localparam logic [1:0] MODE_TX   = 2'b00;
    localparam logic [1:0] MODE_RX   = 2'b01;
    localparam logic [1:0] MODE_TXRX = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO, power-of-two depth.
// Head word is shown combinationally on dout.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; stale contents are harmless once count is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and launch sequencer ahead of the UART controller.
// Pops one byte per frame and waits for the frame to finish.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 8,
    localparam int ADDR_W      = $clog2(DEPTH),
    localparam int TMO_W       = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow,
    input  logic                   ovf_clr,
    input  logic                   tx_enable,
    output logic [UART_BYTE_W-1:0] tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   timeout_err
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    tx_state_e              state;
    tx_state_e              state_nxt;
    logic                   pop;
    logic [UART_BYTE_W-1:0] head;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   tmo_hit;

    sync_fifo #(
        .W     (UART_BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_en),
        .din     (wr_data),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // State register, launched byte and busy-wait counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            tx_data <= '0;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                tx_data <= head;
            end
            if (state == ST_WAIT_BUSY) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

    // Sticky drop flag; a dropped write beats a same-cycle clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Launch sequencing: next state, pop, start pulse, timeout pulse.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!empty && tx_enable && !tx_busy) begin
                    pop       = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_start  = 1'b1;
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (tmo_hit) begin
                    timeout_err = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue with a behavioural UART stub.
// Directed steps plus a randomized push/enable phase against a queue model.
module tb_uart_tx_queue;

    localparam int DEPTH = 16;
    localparam int TMO   = 8;

    logic       clk;
    logic       reset_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;
    logic       tx_enable;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // stub controller knobs
    bit stub_dead = 0;
    int long_len  = 0;
    int ph        = 0;
    int dly       = 0;
    int len       = 0;

    logic [7:0] got[$];
    int         got_cyc[$];
    int         tmo_cyc[$];
    int         last_start = -100;

    uart_tx_queue #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .tx_enable   (tx_enable),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stub: busy rises 0..3 cycles after tx_start, holds 1..6 cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_busy <= 1'b0;
            ph = 0;
        end else begin
            case (ph)
                0: if (tx_start && !stub_dead) begin
                    dly = $urandom_range(0, 3);
                    ph  = 1;
                end
                1: if (dly == 0) begin
                    tx_busy <= 1'b1;
                    len = (long_len != 0) ? long_len : $urandom_range(1, 6);
                    ph  = 2;
                end else begin
                    dly--;
                end
                default: if (len <= 1) begin
                    tx_busy <= 1'b0;
                    ph = 0;
                end else begin
                    len--;
                end
            endcase
        end
    end

    // Launch monitor: record bytes and check launch preconditions.
    always @(negedge clk) begin
        if (reset_n && tx_start) begin
            check("busy_low_at_start", int'(tx_busy), 0);
            checks++;
            assert (cyc - last_start >= 3) else begin
                errors++;
                $error("FAIL start_gap observed=%0d expected>=3",
                       cyc - last_start);
            end
            last_start = cyc;
            got.push_back(tx_data);
            got_cyc.push_back(cyc);
        end
        if (reset_n && timeout_err) begin
            tmo_cyc.push_back(cyc);
        end
    end

    task automatic drain();
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 14; i++) begin
            @(negedge clk);
            if (empty && !tx_busy && ph == 0) quiet++;
            else quiet = 0;
        end
        check("drain_done", int'(quiet >= 14), 1);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        wr_data = b;
        wr_en   = 1'b1;
    endtask

    task automatic idle_in();
        @(negedge clk);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] b;
    int         pushed;
    int         found;

    initial begin
        reset_n   = 0;
        wr_data   = 0;
        wr_en     = 0;
        ovf_clr   = 0;
        tx_enable = 1;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", int'(tx_start), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_full", int'(full), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_timeout", int'(timeout_err), 0);
        reset_n = 1;
        repeat (2) @(negedge clk);

        // single byte, earliest launch timing
        got.delete();
        push(8'h41);
        @(negedge clk);
        wr_en = 0;
        check("single_count", int'(count), 1);
        check("single_empty", int'(empty), 0);
        check("single_nostart", int'(tx_start), 0);
        @(negedge clk);
        check("single_start", int'(tx_start), 1);
        check("single_data", int'(tx_data), 8'h41);
        check("single_popped", int'(empty), 1);
        drain();
        check("single_nlaunch", got.size(), 1);

        // burst with launches held off, then ordered release
        got.delete();
        tx_enable = 0;
        for (int i = 0; i < 3; i++) begin
            push(8'h41 + 8'(i));
            @(negedge clk);
            wr_en = 0;
            check("burst_count", int'(count), i + 1);
            wr_en = 0;
        end
        tx_enable = 1;
        drain();
        check("burst_n", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            check("burst_order", int'(got[i]), 8'h41 + i);
        end

        // overflow: 17 writes with launches disabled
        got.delete();
        tx_enable = 0;
        for (int i = 0; i <= 16; i++) push(8'(i));
        idle_in();
        check("ovf_full", int'(full), 1);
        check("ovf_count", int'(count), 16);
        check("ovf_flag", int'(overflow), 1);
        push(8'hAA);
        ovf_clr = 1;
        idle_in();
        check("ovf_set_wins", int'(overflow), 1);
        @(negedge clk);
        ovf_clr = 1;
        idle_in();
        check("ovf_cleared", int'(overflow), 0);
        tx_enable = 1;
        drain();
        check("ovf_n", got.size(), 16);
        found = 0;
        foreach (got[i]) if (got[i] != 8'(i)) found++;
        check("ovf_sequence_bad", found, 0);

        // gating mid-frame
        got.delete();
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
        idle_in();
        begin
            int k = 0;
            while (k < 50 && got.size() == 0) begin
                @(negedge clk);
                k++;
            end
        end
        tx_enable = 0;
        repeat (40) @(negedge clk);
        check("gate_one_frame", got.size(), 1);
        check("gate_retained", int'(count), 3);
        tx_enable = 1;
        drain();
        check("gate_n", got.size(), 4);
        found = 0;
        foreach (got[i]) if (got[i] != 8'hC0 + 8'(i)) found++;
        check("gate_order_bad", found, 0);

        // timeout with a dead controller
        got.delete();
        tmo_cyc.delete();
        got_cyc.delete();
        stub_dead = 1;
        push(8'h5A);
        push(8'h5B);
        idle_in();
        drain();
        check("tmo_launches", got.size(), 2);
        check("tmo_pulses", tmo_cyc.size(), 2);
        if (got.size() == 2 && tmo_cyc.size() == 2) begin
            check("tmo_delay", tmo_cyc[0] - got_cyc[0], TMO);
            check("tmo_relaunch", got_cyc[1] - tmo_cyc[0], 2);
            check("tmo_second", int'(got[1]), 8'h5B);
        end
        stub_dead = 0;

        // randomized pushes and enable toggling against a queue model
        got.delete();
        exp_q.delete();
        pushed = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            wr_en = 0;
            if ($urandom_range(0, 19) == 0) tx_enable = ~tx_enable;
            if ($urandom_range(0, 2) == 0 && pushed - got.size() < DEPTH) begin
                b = 8'($urandom);
                wr_data = b;
                wr_en = 1;
                exp_q.push_back(b);
                pushed++;
            end
        end
        @(negedge clk);
        wr_en = 0;
        tx_enable = 1;
        drain();
        check("rand_n", got.size(), exp_q.size());
        found = 0;
        foreach (exp_q[i]) if (i < got.size() && got[i] != exp_q[i]) found++;
        check("rand_order_bad", found, 0);
        check("rand_no_ovf", int'(overflow), 0);

        // async reset during WAIT_DONE
        got.delete();
        long_len = 20;
        for (int i = 0; i < 3; i++) push(8'h70 + 8'(i));
        idle_in();
        begin
            int k = 0;
            while (k < 50 && !tx_busy) begin
                @(negedge clk);
                k++;
            end
            check("rst_busy_seen", int'(tx_busy), 1);
        end
        repeat (2) @(negedge clk);
        #2 reset_n = 0;
        #1;
        check("arst_tx_start", int'(tx_start), 0);
        check("arst_tx_data", int'(tx_data), 0);
        check("arst_count", int'(count), 0);
        check("arst_empty", int'(empty), 1);
        check("arst_full", int'(full), 0);
        check("arst_timeout", int'(timeout_err), 0);
        long_len = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (12) @(negedge clk);
        check("arst_count_after", int'(count), 0);
        check("arst_no_launch", got.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte FIFO and launch sequencer that sits directly upstream of `UART_Controller`, feeding its `tx_data`/`tx_start` pins. Producers push bytes at any rate up to one per clock. The block pops one byte at a time, pulses `tx_start`, and tracks `tx_busy` until the frame completes. Producers therefore never have to poll the UART themselves.

## Interface
- `DEPTH`, 16, FIFO entries; must be a power of two, ≥2.
- `BUSY_TIMEOUT`, 8, cycles to wait for `tx_busy` to rise after a launch before treating the byte as consumed.
- `clk` input 1 system clock; all logic on its rising edge.
- `reset_n` input 1 asynchronous, active-low reset.
- `wr_data` input 8 byte to enqueue.
- `wr_en` input 1 enqueue strobe, one byte per cycle.
- `full` output 1 `count == DEPTH`.
- `empty` output 1 `count == 0`.
- `count` output clog2(DEPTH)+1 current occupancy.
- `overflow` output 1 sticky; set when a write is dropped.
- `ovf_clr` input 1 clears `overflow`.
- `tx_enable` input 1 launches allowed; driven low when the controller is in RX-only mode (`mode == 2'b01`).
- `tx_data` output 8 byte presented to `UART_Controller`.
- `tx_start` output 1 single-cycle launch pulse.
- `tx_busy` input 1 controller busy flag.
- `timeout_err` output 1 single-cycle pulse when `BUSY_TIMEOUT` expires.

## Operation
- **FIFO storage**
  - Circular buffer with `ADDR_W = clog2(DEPTH)`-bit read and write pointers that wrap modulo `DEPTH`.
  - `count` is held as a separate register.
- **Write path**
  - `wr_en && !full`: store the byte at the write pointer, increment the pointer and `count`.
  - `wr_en && full`: drop the byte and set `overflow`. This applies even if a pop occurs in the same cycle, since `full` is evaluated on the registered `count`.
- **Overflow flag**
  - `ovf_clr` clears `overflow`.
  - If `ovf_clr` and an overflowing write occur in the same cycle, set wins.
- **Simultaneous push and pop** (not full): `count` is unchanged and both pointers advance.
- **Launch FSM states:** IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE → LAUNCH when `!empty && tx_enable && !tx_busy`. The head byte is latched into the `tx_data` register and the read pointer advances (pop) in this transition cycle.
  - LAUNCH: `tx_start = 1` for exactly this cycle. Always goes to WAIT_BUSY.
  - WAIT_BUSY:
    - → WAIT_DONE when `tx_busy == 1`.
    - If `tx_busy` stays low for `BUSY_TIMEOUT` cycles, pulse `timeout_err` and go to IDLE. The byte is lost and not retried.
  - WAIT_DONE: → IDLE when `tx_busy == 0`.
- **`tx_data` stability:** held constant from LAUNCH until the next pop.
- **`tx_enable` deassertion:**
  - Only gates the IDLE → LAUNCH transition.
  - A frame already in flight runs to completion.
  - Queued bytes are retained.

## Timing
- **Reset values:**
  - `tx_start = 0`, `tx_data = 8'h00`, `full = 0`, `empty = 1`, `count = 0`, `overflow = 0`, `timeout_err = 0`.
  - FSM in IDLE, pointers 0.
- **Reset mid-operation:** asynchronously clears all state, including queued bytes. `tx_start` drops immediately.
- **Write to `empty` deassert:** byte written in cycle N → `empty = 0` in N+1.
- **Earliest `tx_start`:** byte written in cycle N with the UART idle → IDLE → LAUNCH transition in N+1, `tx_start` high in N+2.
- **Back-to-back bytes:** the minimum gap between `tx_start` pulses is the frame's `tx_busy` duration plus 2 cycles (WAIT_DONE → IDLE → LAUNCH).
- **`timeout_err` timing:** asserted in the cycle WAIT_BUSY exits on timeout. WAIT_BUSY's counter starts at 0 on entry.
- **Flag update:** `full`, `empty` and `count` reflect the state after the edge. There is no combinational path from `wr_en` to `full`.

## Structure
- **Shared package `uart_pkg`:**
  - FSM state encoding (2-bit).
  - `UART_BYTE_W = 8`.
  - Mode constants `MODE_TX = 2'b00`, `MODE_RX = 2'b01`, `MODE_TXRX = 2'b10`, so the integration layer can derive `tx_enable = (mode != MODE_RX)`.
- **Sub-module `sync_fifo`:** natural split (parameterised width/depth; `push`/`pop`/`full`/`empty`/`count`). `uart_tx_queue` adds the launch FSM, timeout counter and `overflow` flag.

## Test plan
- **Single byte:** after reset, write 8'h41 with the controller looped back. Exactly one `tx_start`, `tx_data = 8'h41` during it; `rx_valid` later shows 8'h41; `empty = 1` after pop.
- **Burst and ordering:** write 8'h41, 8'h42, 8'h43 on consecutive cycles. `count` goes 1, 2, 3 and then decrements. Three `tx_start` pulses in order A, B, C, each only after `tx_busy` has fallen. Loopback receives A, B, C.
- **Overflow:** `DEPTH = 16`, `tx_enable = 0`, write 17 bytes 8'h00–8'h10. `full = 1`, `count = 16`, `overflow = 1`, byte 8'h10 absent from output. Then `ovf_clr` → `overflow = 0`; enable → 16 frames, 8'h00–8'h0F.
- **Gating:** `tx_enable` dropped mid-frame. Current frame completes; no further `tx_start` while low; remaining bytes go out after re-enable.
- **Timeout:** hold `tx_busy = 0` with a stubbed controller. `timeout_err` pulses exactly `BUSY_TIMEOUT` cycles after WAIT_BUSY entry; FSM returns to IDLE and launches the next byte.
- **Async reset mid-frame:** assert `reset_n = 0` in WAIT_DONE. All outputs take reset values immediately; `count = 0` after release.
